// File: rtl/instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// instr_fetch_unit
//
// Instruction fetch stage sitting directly in front of the main decoder.
// It holds the PC and keeps at most one request outstanding to instruction
// memory over a req/gnt/rvalid handshake. It hands the returned word, with
// its PC and opcode field, to decode over a valid/ready handshake. PC
// redirects (taken branch, jal, jalr) squash any fetch that is in flight. A
// misaligned redirect target locks the unit in a sticky fault state, which
// only reset can clear.
//
// Ports
//   clk, rst_n          clock; asynchronous active-low reset
//   imem_req            request to instruction memory (high only in REQ)
//   imem_addr           fetch address, always the current PC
//   imem_gnt            memory accepts the request this cycle
//   imem_rvalid         read data valid
//   imem_rdata          returned instruction word
//   redirect_valid      load redirect_pc as the new PC
//   redirect_pc         redirect target
//   instr_valid         instruction available to decode (high only in HOLD)
//   dec_ready           decode consumes the held instruction
//   instr               held instruction word
//   instr_op            instr[6:0], opcode field for the main decoder
//   instr_pc            PC of the held instruction
//   instr_pc_plus4      instr_pc + 4, the jal/jalr link value
//   fetch_count         number of instructions consumed by decode (wraps)
//   fetch_fault         sticky misaligned-redirect fault
// -----------------------------------------------------------------------------
module instr_fetch_unit #(
    parameter int unsigned     XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,

    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,

    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,

    output logic            instr_valid,
    input  logic            dec_ready,
    output logic [31:0]     instr,
    output logic [6:0]      instr_op,
    output logic [XLEN-1:0] instr_pc,
    output logic [XLEN-1:0] instr_pc_plus4,
    output logic [31:0]     fetch_count,
    output logic            fetch_fault
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        HOLD  = 3'd3,
        FAULT = 3'd4
    } state_t;

    state_t            state, state_next;
    logic [XLEN-1:0]   pc, pc_next;
    logic              kill, kill_next;
    logic [31:0]       instr_q, instr_next;
    logic [XLEN-1:0]   instr_pc_q, instr_pc_next;
    logic [31:0]       count_q, count_next;

    // A redirect to a target that is not word-aligned is a fault, whatever
    // state the unit is in (apart from FAULT itself, which ignores inputs).
    logic redirect_ok;
    logic redirect_bad;

    assign redirect_ok  = redirect_valid && (redirect_pc[1:0] == 2'b00);
    assign redirect_bad = redirect_valid && (redirect_pc[1:0] != 2'b00);

    // -------------------------------------------------------------------------
    // State and datapath registers
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples the pre-edge values, whatever the order of statements.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            kill       <= 1'b0;
            instr_q    <= '0;
            instr_pc_q <= '0;
            count_q    <= '0;
        end else begin
            state      <= state_next;
            pc         <= pc_next;
            kill       <= kill_next;
            instr_q    <= instr_next;
            instr_pc_q <= instr_pc_next;
            count_q    <= count_next;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and next-datapath logic
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a hold value first, so any path that does not
    // assign it keeps the register contents and no latch is inferred.
    always_comb begin
        state_next    = state;
        pc_next       = pc;
        kill_next     = kill;
        instr_next    = instr_q;
        instr_pc_next = instr_pc_q;
        count_next    = count_q;

        unique case (state)
            IDLE: begin
                if (redirect_bad) begin
                    state_next = FAULT;
                end else begin
                    if (redirect_ok) begin
                        pc_next = redirect_pc;
                    end
                    state_next = REQ;
                end
            end

            REQ: begin
                if (redirect_bad) begin
                    state_next = FAULT;
                end else if (imem_gnt) begin
                    // The request at the old PC is already accepted. A
                    // redirect in the same cycle marks its response as dead.
                    if (redirect_ok) begin
                        pc_next   = redirect_pc;
                        kill_next = 1'b1;
                    end
                    state_next = WAIT;
                end else if (redirect_ok) begin
                    // Nothing is accepted yet, so the request just retargets.
                    pc_next = redirect_pc;
                end
            end

            WAIT: begin
                if (redirect_bad) begin
                    kill_next  = 1'b0;
                    state_next = FAULT;
                end else if (imem_rvalid) begin
                    kill_next  = 1'b0;
                    state_next = REQ;
                    if (redirect_ok) begin
                        pc_next = redirect_pc;
                    end else if (!kill) begin
                        instr_next    = imem_rdata;
                        instr_pc_next = pc;
                        state_next    = HOLD;
                    end
                end else if (redirect_ok) begin
                    pc_next   = redirect_pc;
                    kill_next = 1'b1;
                end
            end

            HOLD: begin
                if (redirect_bad) begin
                    state_next = FAULT;
                end else if (redirect_ok) begin
                    // The held instruction is on the wrong path. Dropping it
                    // means decode never consumed it, so the count is unchanged.
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (dec_ready) begin
                    pc_next    = pc + XLEN'(4);
                    count_next = count_q + 32'd1;
                    state_next = REQ;
                end
            end

            FAULT: begin
                state_next = FAULT;
            end

            default: begin
                state_next = FAULT;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Outputs: decoded from state or taken straight from registers
    // -------------------------------------------------------------------------
    assign imem_req       = (state == REQ);
    assign imem_addr      = pc;
    assign instr_valid    = (state == HOLD);
    assign fetch_fault    = (state == FAULT);
    assign instr          = instr_q;
    assign instr_op       = instr_q[6:0];
    assign instr_pc       = instr_pc_q;
    assign instr_pc_plus4 = instr_pc_q + XLEN'(4);
    assign fetch_count    = count_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_unit
//
// Directed bench for instr_fetch_unit with RESET_PC = 0x100. Inputs are
// driven 1 ns after each rising edge. Outputs are checked at the same point,
// after the registers have settled from that edge.
// -----------------------------------------------------------------------------
module tb_instr_fetch_unit;

    localparam int unsigned     XLEN     = 32;
    localparam logic [XLEN-1:0] RESET_PC = 32'h0000_0100;

    logic            clk;
    logic            rst_n;
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_gnt;
    logic            imem_rvalid;
    logic [31:0]     imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            dec_ready;
    logic [31:0]     instr;
    logic [6:0]      instr_op;
    logic [XLEN-1:0] instr_pc;
    logic [XLEN-1:0] instr_pc_plus4;
    logic [31:0]     fetch_count;
    logic            fetch_fault;

    int checks = 0;
    int errors = 0;

    instr_fetch_unit #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .dec_ready      (dec_ready),
        .instr          (instr),
        .instr_op       (instr_op),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4),
        .fetch_count    (fetch_count),
        .fetch_fault    (fetch_fault)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] actual,
                         input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        dec_ready      = 1'b0;
    endtask

    // From REQ: grant now, return data after 'lat' cycles, and land in HOLD.
    task automatic fetch(input logic [31:0] data, input int lat);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        for (int i = 1; i < lat; i++) step();
        imem_rvalid = 1'b1;
        imem_rdata  = data;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        idle_inputs();

        // ---------------- Reset ----------------
        step();
        step();
        check("rst_req",    {31'd0, imem_req},    32'd0);
        check("rst_valid",  {31'd0, instr_valid}, 32'd0);
        check("rst_fault",  {31'd0, fetch_fault}, 32'd0);
        check("rst_addr",   imem_addr,            32'h100);
        check("rst_count",  fetch_count,          32'd0);
        check("rst_instr",  instr,                32'd0);
        check("rst_ipc",    instr_pc,             32'd0);
        rst_n = 1'b1;
        check("idle_req",   {31'd0, imem_req},    32'd0);
        step();
        check("req_rise",   {31'd0, imem_req},    32'd1);
        check("req_addr",   imem_addr,            32'h100);

        // ---------------- Sequential fetch ----------------
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        check("wait_req",   {31'd0, imem_req},    32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0050_0093;
        step();
        imem_rvalid = 1'b0;
        check("seq_valid",  {31'd0, instr_valid}, 32'd1);
        check("seq_instr",  instr,                32'h0050_0093);
        check("seq_op",     {25'd0, instr_op},    32'h13);
        check("seq_pc",     instr_pc,             32'h100);
        check("seq_pc4",    instr_pc_plus4,       32'h104);

        // ---------------- Backpressure ----------------
        for (int i = 0; i < 5; i++) begin
            step();
            check("bp_instr", instr,                32'h0050_0093);
            check("bp_req",   {31'd0, imem_req},    32'd0);
            check("bp_valid", {31'd0, instr_valid}, 32'd1);
            check("bp_addr",  imem_addr,            32'h100);
        end
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("adv_addr",   imem_addr,            32'h104);
        check("adv_count",  fetch_count,          32'd1);
        check("adv_req",    {31'd0, imem_req},    32'd1);
        check("adv_valid",  {31'd0, instr_valid}, 32'd0);

        // ---------------- Squash in WAIT ----------------
        imem_gnt = 1'b1;
        step();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step();
        redirect_valid = 1'b0;
        check("sq_addr",    imem_addr,            32'h200);
        check("sq_req",     {31'd0, imem_req},    32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        step();
        imem_rvalid = 1'b0;
        check("sq_valid",   {31'd0, instr_valid}, 32'd0);
        check("sq_req2",    {31'd0, imem_req},    32'd1);
        check("sq_addr2",   imem_addr,            32'h200);
        check("sq_count",   fetch_count,          32'd1);

        // ---------------- Redirect beats dec_ready in HOLD ----------------
        fetch(32'h0000_006F, 1);
        check("pr_valid",   {31'd0, instr_valid}, 32'd1);
        check("pr_ipc",     instr_pc,             32'h200);
        check("pr_op",      {25'd0, instr_op},    32'h6F);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h300;
        dec_ready      = 1'b1;
        step();
        idle_inputs();
        check("pr_addr",    imem_addr,            32'h300);
        check("pr_count",   fetch_count,          32'd1);
        check("pr_req",     {31'd0, imem_req},    32'd1);

        // ---------------- gnt + redirect in the same REQ cycle ----------------
        imem_gnt       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step();
        idle_inputs();
        check("gr_addr",    imem_addr,            32'h400);
        check("gr_req",     {31'd0, imem_req},    32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1111_1111;
        step();
        imem_rvalid = 1'b0;
        check("gr_valid",   {31'd0, instr_valid}, 32'd0);
        check("gr_req2",    {31'd0, imem_req},    32'd1);

        // ---------------- Redirect in REQ without gnt ----------------
        redirect_valid = 1'b1;
        redirect_pc    = 32'h500;
        step();
        redirect_valid = 1'b0;
        check("rq_req",     {31'd0, imem_req},    32'd1);
        check("rq_addr",    imem_addr,            32'h500);

        // ---------------- Redirect together with rvalid in WAIT ----------------
        imem_gnt = 1'b1;
        step();
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b1;
        imem_rdata     = 32'h2222_2222;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h600;
        step();
        idle_inputs();
        check("rv_valid",   {31'd0, instr_valid}, 32'd0);
        check("rv_req",     {31'd0, imem_req},    32'd1);
        check("rv_addr",    imem_addr,            32'h600);

        // ---------------- Slow memory: rvalid 3 cycles after gnt ----------------
        fetch(32'h0000_0013, 3);
        check("sl_valid",   {31'd0, instr_valid}, 32'd1);
        check("sl_ipc",     instr_pc,             32'h600);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("sl_addr",    imem_addr,            32'h604);
        check("sl_count",   fetch_count,          32'd2);

        // ---------------- PC wrap at the top of the address space ----------------
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        step();
        redirect_valid = 1'b0;
        fetch(32'h0000_0033, 1);
        check("wr_ipc",     instr_pc,             32'hFFFF_FFFC);
        check("wr_pc4",     instr_pc_plus4,       32'h0);
        dec_ready = 1'b1;
        step();
        dec_ready = 1'b0;
        check("wr_addr",    imem_addr,            32'h0);
        check("wr_count",   fetch_count,          32'd3);

        // ---------------- Misaligned redirect -> sticky fault ----------------
        imem_gnt = 1'b1;
        step();
        imem_gnt       = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h202;
        step();
        redirect_valid = 1'b0;
        check("ft_fault",   {31'd0, fetch_fault}, 32'd1);
        check("ft_req",     {31'd0, imem_req},    32'd0);
        for (int i = 0; i < 10; i++) begin
            imem_rvalid    = i[0];
            imem_gnt       = ~i[0];
            redirect_valid = 1'b1;
            redirect_pc    = 32'h1000 + 32'(i) * 32'd4;
            dec_ready      = 1'b1;
            imem_rdata     = 32'h0000_0013;
            step();
            check("ft_hold",  {31'd0, fetch_fault}, 32'd1);
            check("ft_req_h", {31'd0, imem_req},    32'd0);
            check("ft_val_h", {31'd0, instr_valid}, 32'd0);
            check("ft_cnt_h", fetch_count,          32'd3);
        end
        idle_inputs();

        // ---------------- Reset clears the fault ----------------
        rst_n = 1'b0;
        #1;
        check("fr_fault",   {31'd0, fetch_fault}, 32'd0);
        check("fr_addr",    imem_addr,            32'h100);
        check("fr_count",   fetch_count,          32'd0);
        step();
        rst_n = 1'b1;
        step();
        check("fr_req",     {31'd0, imem_req},    32'd1);
        check("fr_addr2",   imem_addr,            32'h100);
        fetch(32'h0050_0093, 1);
        check("fr_valid",   {31'd0, instr_valid}, 32'd1);
        check("fr_ipc",     instr_pc,             32'h100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
